// File: rtl/rtc_bus_sequencer_if.sv
// rtc_bus_sequencer_if: requester handshakes plus the RTC multiplexed A_D/CS/RD/WR/AD pad signals.
interface rtc_bus_sequencer_if;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_gnt;
    logic       wr_gnt;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       wr_done;
    logic       busy;
    logic       A_D;
    logic       CS;
    logic       RD;
    logic       WR;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] bus_in;
    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, bus_in,
        output rd_gnt, wr_gnt, rd_data, rd_valid, wr_done, busy, A_D, CS, RD, WR, bus_out, bus_oe
    );
    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, bus_in,
        input  rd_gnt, wr_gnt, rd_data, rd_valid, wr_done, busy, A_D, CS, RD, WR, bus_out, bus_oe
    );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: round-robin read/write arbiter running one timed multiplexed RTC bus cycle per grant.
module rtc_bus_sequencer #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 5,
    parameter int T_HOLD  = 2,
    parameter int T_RECOV = 4
) (
    input logic               clk,
    input logic               reset,
    rtc_bus_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, A_SET, A_STB, A_HOLD, D_SET, D_STB, D_HOLD, RECOV} state_t;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       dir_wr_q, dir_wr_d, last_wr_q, last_wr_d;
    logic [7:0] addr_q, addr_d, data_q, data_d, rd_data_q, rd_data_d, bus_out_q, bus_out_d;
    logic       cs_q, cs_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, a_d_q, a_d_d, oe_q, oe_d;
    logic       rd_gnt_q, rd_gnt_d, wr_gnt_q, wr_gnt_d, rd_valid_q, rd_valid_d;
    logic       wr_done_q, wr_done_d, busy_q, busy_d;
    logic       wr_win, start, last, addr_ph, data_ph;
    function automatic logic [3:0] load(input state_t s);
        return (s == A_SET || s == D_SET)   ? 4'(T_SETUP - 1) :
               (s == A_STB || s == D_STB)   ? 4'(T_PULSE - 1) :
               (s == A_HOLD || s == D_HOLD) ? 4'(T_HOLD - 1)  :
               (s == RECOV)                 ? 4'(T_RECOV - 1) : 4'd0;
    endfunction
    // Outputs are derived from the next state so every pad signal leaves a flop.
    always_comb begin
        wr_win     = bus.wr_req && (!bus.rd_req || !last_wr_q);
        start      = state_q == IDLE && (bus.rd_req || bus.wr_req);
        last       = cnt_q == 4'd0;
        state_d    = start ? A_SET : (state_q == IDLE || !last) ? state_q :
                     state_q == RECOV ? IDLE : state_t'(state_q + 3'd1);
        cnt_d      = state_d != state_q ? load(state_d) : cnt_q - 4'd1;
        dir_wr_d   = start ? wr_win : dir_wr_q;
        last_wr_d  = start ? wr_win : last_wr_q;
        addr_d     = start ? (wr_win ? bus.wr_addr : bus.rd_addr) : addr_q;
        data_d     = (start && wr_win) ? bus.wr_data : data_q;
        rd_data_d  = (state_q == D_STB && last && !dir_wr_q) ? bus.bus_in : rd_data_q;
        addr_ph    = state_d == A_SET || state_d == A_STB || state_d == A_HOLD;
        data_ph    = state_d == D_SET || state_d == D_STB || state_d == D_HOLD;
        cs_d       = !(addr_ph || data_ph);
        a_d_d      = !addr_ph;
        oe_d       = addr_ph || (data_ph && dir_wr_d);
        bus_out_d  = addr_ph ? addr_d : (data_ph && dir_wr_d) ? data_d : 8'h00;
        wr_n_d     = !(state_d == A_STB || (state_d == D_STB && dir_wr_d));
        rd_n_d     = !(state_d == D_STB && !dir_wr_d);
        rd_gnt_d   = start && !wr_win;
        wr_gnt_d   = start && wr_win;
        rd_valid_d = state_q == D_HOLD && state_d == RECOV && !dir_wr_q;
        wr_done_d  = state_q == D_HOLD && state_d == RECOV && dir_wr_q;
        busy_d     = state_d != IDLE;
    end
    // last_wr_q resets low so the first conflict goes to the write path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            dir_wr_q   <= 1'b0;
            last_wr_q  <= 1'b0;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            rd_data_q  <= 8'h00;
            bus_out_q  <= 8'h00;
            cs_q       <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            a_d_q      <= 1'b1;
            oe_q       <= 1'b0;
            rd_gnt_q   <= 1'b0;
            wr_gnt_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_wr_q   <= dir_wr_d;
            last_wr_q  <= last_wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            bus_out_q  <= bus_out_d;
            cs_q       <= cs_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            a_d_q      <= a_d_d;
            oe_q       <= oe_d;
            rd_gnt_q   <= rd_gnt_d;
            wr_gnt_q   <= wr_gnt_d;
            rd_valid_q <= rd_valid_d;
            wr_done_q  <= wr_done_d;
            busy_q     <= busy_d;
        end
    end
    assign bus.rd_gnt   = rd_gnt_q;
    assign bus.wr_gnt   = wr_gnt_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.wr_done  = wr_done_q;
    assign bus.busy     = busy_q;
    assign bus.A_D      = a_d_q;
    assign bus.CS       = cs_q;
    assign bus.RD       = rd_n_q;
    assign bus.WR       = wr_n_q;
    assign bus.bus_out  = bus_out_q;
    assign bus.bus_oe   = oe_q;
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: scoreboard bench for default and fast-timing sequencers; pads return addr^0x64 on reads.
module tb_rtc_bus_sequencer;
    typedef struct {bit w; logic [7:0] a; logic [7:0] d;} exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   fast = 1'b0;
    logic rd_req = 1'b0, wr_req = 1'b0;
    logic [7:0] rd_addr = 8'h00, wr_addr = 8'h00, wr_data = 8'h00, lat_addr = 8'h00;
    logic m_rd_gnt, m_wr_gnt, m_rd_valid, m_wr_done, m_busy, m_a_d, m_cs, m_rd, m_wr, m_oe;
    logic [7:0] m_bus_out, m_rd_data;
    exp_t exp_q[$];
    int checks = 0, errors = 0, cyc = 0, g_cyc = 0, done_cnt = 0;
    int wr_run = 0, rd_run = 0, cs_run = 0, cs_gap = 0;
    bit prev_done = 0, prev_g = 0, g_wr = 0;
    logic [7:0] cap_a = 8'h00, cap_d = 8'h00;
    int pulse, lat, recov;
    always #5 clk = ~clk;
    rtc_bus_sequencer_if ifs();
    rtc_bus_sequencer_if ifs_f();
    rtc_bus_sequencer dut (.clk(clk), .reset(rst_n), .bus(ifs.slave));
    rtc_bus_sequencer #(.T_SETUP(1), .T_PULSE(3), .T_HOLD(1), .T_RECOV(2)) dut_f (.clk(clk), .reset(rst_n), .bus(ifs_f.slave));
    assign ifs.rd_req    = rd_req & !fast;
    assign ifs.wr_req    = wr_req & !fast;
    assign ifs_f.rd_req  = rd_req & fast;
    assign ifs_f.wr_req  = wr_req & fast;
    assign ifs.rd_addr   = rd_addr;
    assign ifs_f.rd_addr = rd_addr;
    assign ifs.wr_addr   = wr_addr;
    assign ifs_f.wr_addr = wr_addr;
    assign ifs.wr_data   = wr_data;
    assign ifs_f.wr_data = wr_data;
    assign ifs.bus_in    = lat_addr ^ 8'h64;
    assign ifs_f.bus_in  = lat_addr ^ 8'h64;
    always_comb begin
        m_rd_gnt   = fast ? ifs_f.rd_gnt   : ifs.rd_gnt;
        m_wr_gnt   = fast ? ifs_f.wr_gnt   : ifs.wr_gnt;
        m_rd_valid = fast ? ifs_f.rd_valid : ifs.rd_valid;
        m_wr_done  = fast ? ifs_f.wr_done  : ifs.wr_done;
        m_busy     = fast ? ifs_f.busy     : ifs.busy;
        m_a_d      = fast ? ifs_f.A_D      : ifs.A_D;
        m_cs       = fast ? ifs_f.CS       : ifs.CS;
        m_rd       = fast ? ifs_f.RD       : ifs.RD;
        m_wr       = fast ? ifs_f.WR       : ifs.WR;
        m_oe       = fast ? ifs_f.bus_oe   : ifs.bus_oe;
        m_bus_out  = fast ? ifs_f.bus_out  : ifs.bus_out;
        m_rd_data  = fast ? ifs_f.rd_data  : ifs.rd_data;
        pulse      = fast ? 3 : 5;
        lat        = fast ? 10 : 18;
        recov      = fast ? 2 : 4;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic push(input bit w, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.w = w;
        e.a = a;
        e.d = w ? d : (a ^ 8'h64);
        exp_q.push_back(e);
    endtask
    task automatic do_req(input bit w, input logic [7:0] a, input logic [7:0] d);
        bit got = 0;
        if (w) begin wr_addr = a; wr_data = d; wr_req = 1'b1; end
        else begin rd_addr = a; rd_req = 1'b1; end
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = w ? m_wr_gnt : m_rd_gnt;
        end
        if (!got) chk("gnt_timeout", 0, 1);
        if (w) wr_req = 1'b0; else rd_req = 1'b0;
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 400 && (exp_q.size() != 0 || m_busy); i++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 0);
    endtask
    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask
    // Protocol monitor: grant order, phase signalling, strobe widths, completion data and latency.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            wr_run = 0; rd_run = 0; cs_run = 0; prev_done = 0; prev_g = 0;
        end else begin
            if (m_cs) cs_run++;
            else if (cs_run != 0) begin cs_gap = cs_run; cs_run = 0; end
            if (m_rd_gnt || m_wr_gnt) begin
                if (prev_g) chk("gnt_width", 2, 1);
                if (exp_q.size() == 0) chk("gnt_unexpected", 1, 0);
                else begin
                    chk("gnt_dir", 32'(m_wr_gnt), 32'(exp_q[0].w));
                    chk("a_phase", {m_cs, m_a_d, m_oe, m_rd_gnt & m_wr_gnt}, 4'b0010);
                    chk("a_addr", m_bus_out, exp_q[0].a);
                end
                if (prev_done) chk("cs_gap", 32'(cs_gap >= recov + 1), 1);
                g_cyc = cyc;
                g_wr  = m_wr_gnt;
            end
            prev_g = m_rd_gnt || m_wr_gnt;
            if (!m_cs && !m_a_d) lat_addr = m_bus_out;
            if (!m_wr) begin
                wr_run++;
                chk("wr_oe", {m_oe, m_cs}, 2'b10);
                if (m_a_d) cap_d = m_bus_out; else cap_a = m_bus_out;
            end else if (wr_run != 0) begin
                chk("wr_width", wr_run, pulse);
                wr_run = 0;
            end
            if (!m_rd) begin
                rd_run++;
                chk("rd_phase", {m_a_d, m_oe, g_wr, m_cs}, 4'b1000);
            end else if (rd_run != 0) begin
                chk("rd_width", rd_run, pulse);
                rd_run = 0;
            end
            if (m_rd_valid || m_wr_done) begin
                if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("done_dir", {m_rd_valid, m_wr_done}, {!e.w, e.w});
                    chk("addr", cap_a, e.a);
                    chk("data", e.w ? cap_d : m_rd_data, e.d);
                    chk("latency", cyc - g_cyc, lat);
                    chk("recov_pads", {m_cs, m_rd, m_wr, m_oe, m_a_d}, 5'b11101);
                end
                done_cnt++;
                prev_done = 1;
            end
        end
    end
    initial begin
        int d0;
        repeat (2) @(negedge clk);
        chk("rst_pads", {m_cs, m_rd, m_wr, m_a_d, m_oe, m_busy}, 6'b111100);
        chk("rst_pulses", {m_rd_gnt, m_wr_gnt, m_rd_valid, m_wr_done}, 4'b0000);
        chk("rst_bus", {m_bus_out, m_rd_data}, 16'h0000);
        apply_reset();
        push(1, 8'h10, 8'hC3);
        push(0, 8'h11, 8'h00);
        fork
            do_req(1, 8'h10, 8'hC3);
            do_req(0, 8'h11, 8'h00);
        join
        wait_idle();
        push(1, 8'h30, 8'h01);
        push(0, 8'h31, 8'h00);
        push(1, 8'h32, 8'h02);
        push(0, 8'h33, 8'h00);
        fork
            begin do_req(1, 8'h30, 8'h01); do_req(1, 8'h32, 8'h02); end
            begin do_req(0, 8'h31, 8'h00); do_req(0, 8'h33, 8'h00); end
        join
        wait_idle();
        push(0, 8'h21, 8'h00);
        do_req(0, 8'h21, 8'h00);
        wait_idle();
        push(1, 8'h22, 8'h59);
        do_req(1, 8'h22, 8'h59);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            bit w = 1'($urandom_range(0, 1));
            logic [7:0] a = 8'($urandom);
            logic [7:0] d = 8'($urandom);
            push(w, a, d);
            do_req(w, a, d);
        end
        wait_idle();
        push(1, 8'h44, 8'h77);
        do_req(1, 8'h44, 8'h77);
        for (int i = 0; i < 100 && !(m_a_d && !m_wr); i++) @(negedge clk);
        chk("reach_dstb", {m_a_d, m_wr}, 2'b10);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {m_cs, m_wr, m_oe, m_busy}, 4'b1100);
        exp_q.delete();
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_done", done_cnt, d0);
        chk("post_rst_idle", {m_busy, m_cs}, 2'b01);
        fast = 1'b1;
        apply_reset();
        push(0, 8'h5A, 8'h00);
        do_req(0, 8'h5A, 8'h00);
        wait_idle();
        push(1, 8'hA5, 8'h3C);
        do_req(1, 8'hA5, 8'h3C);
        wait_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
Owns the RTC's multiplexed address/data bus (A_D, RD, WR, CS, 8-bit AD bus). It arbitrates between two requesters, a periodic read scanner and a write/programming path, and runs each accepted request as one complete bus cycle with programmable timing. It sits between the processor-side control registers and the top-level tristate pad logic. It replaces ad-hoc strobe sequencing with one timed state machine.

Parameters:
T_SETUP, 2, cycles the address/data is stable before a strobe (1..15)
T_PULSE, 5, strobe (RD/WR) low width in cycles (1..15)
T_HOLD, 2, cycles the address/data is held after the strobe rises (1..15)
T_RECOV, 4, cycles CS stays high between transactions (1..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low
rd_req  in  1  read request, level, held until rd_gnt
rd_addr  in  8  RTC register address for the read
wr_req  in  1  write request, level, held until wr_gnt
wr_addr  in  8  RTC register address for the write
wr_data  in  8  data to write
rd_gnt  out  1  1-cycle pulse: read accepted, rd_addr latched
wr_gnt  out  1  1-cycle pulse: write accepted, wr_addr/wr_data latched
rd_data  out  8  last read result
rd_valid  out  1  1-cycle pulse: rd_data updated
wr_done  out  1  1-cycle pulse: write cycle complete
busy  out  1  high in every state except IDLE
A_D  out  1  0 = address phase, 1 = data phase
CS  out  1  chip select, active-low
RD  out  1  read strobe, active-low
WR  out  1  write strobe, active-low
bus_out  out  8  value driven onto the AD bus
bus_oe  out  1  1 = pads drive bus_out
bus_in  in  8  AD bus value sampled from the pads

Behaviour:
- Reset (asynchronous, active-low, any state): state=IDLE. CS=RD=WR=1, A_D=1, bus_oe=0, bus_out=0, rd_data=0. All pulses are 0 and busy=0. The round-robin pointer favours write.
- States: IDLE, A_SET, A_STB, A_HOLD, D_SET, D_STB, D_HOLD, RECOV. Each timed state lasts its parameter's cycle count. A 4-bit down-counter reloads on state entry.
- IDLE: samples rd_req/wr_req every cycle. If either is high, go to A_SET next cycle. The winner's address, data and direction are latched on that edge.
- Arbitration: with one request, that request wins. With both, the requester not granted last wins. After reset, write wins the first conflict.
- rd_gnt/wr_gnt: high for exactly the first A_SET cycle. A requester may drop or change its request from the next cycle.
- Address phase (A_SET, A_STB, A_HOLD): CS=0, A_D=0, bus_oe=1, bus_out=latched addr. WR=0 only in A_STB. RD=1.
- Data phase (D_SET, D_STB, D_HOLD): CS=0, A_D=1.
  - Write: bus_oe=1, bus_out=latched data, WR=0 only in D_STB.
  - Read: bus_oe=0, RD=0 only in D_STB. rd_data captures bus_in on the last D_STB cycle.
- RECOV: CS=1, RD=WR=1, A_D=1, bus_oe=0. The first RECOV cycle pulses rd_valid (read) or wr_done (write). After T_RECOV cycles, go to IDLE.
- Latency, default params: grant to completion pulse is 2+5+2+2+5+2 = 18 cycles. IDLE to IDLE is 22 cycles plus 1 IDLE sampling cycle.
- Requests arriving while busy are not lost. They are held by the requester and evaluated at the next IDLE.
- Glitch-free outputs: CS, RD, WR, A_D, bus_oe and bus_out are all registered. No strobe changes in the same cycle as A_D or the address/data.
- Reset mid-transaction: strobes return high immediately and asynchronously. No completion pulse is issued. The requester must re-request.
- Parameter value 0 is illegal. The design is not required to handle it.

Test Plan:
- Read: rd_req=1, rd_addr=0x21, bus_in=0x45 in D_STB -> rd_gnt 1 cycle. Address phase: CS=0, A_D=0, bus_out=0x21, WR low 5 cycles. Data phase: RD low 5 cycles, bus_oe=0. rd_valid 18 cycles after rd_gnt, rd_data=0x45.
- Write: wr_req=1, wr_addr=0x22, wr_data=0x59 -> address 0x22 then data 0x59 each with a WR low 5 cycles. RD never low. wr_done pulses, then CS high 4 cycles.
- Simultaneous first requests after reset: rd_req and wr_req both high -> write served first. The read is granted at the next IDLE with no overlap of CS between cycles.
- Fairness: both requests held high continuously -> grants alternate W, R, W, R for 4 transactions.
- Reset mid-cycle: assert reset low during D_STB of a write -> WR, CS high and bus_oe=0 in the same cycle. No wr_done. After release, state=IDLE and busy=0.
- Timing parameters T_SETUP=1, T_PULSE=3, T_HOLD=1, T_RECOV=2: check strobe width 3 and grant-to-done latency 10 cycles.
